// File: rtl/vram_dma.sv
// VRAM DMA engine: CPU-programmed fill/copy over the video block's CPU port.
// One byte per iteration; every iteration is an access state followed by a wait state and an optional stall state.
module vram_dma (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        irq,
    output logic        bus_req,
    output logic        v_sel,
    output logic        v_we,
    output logic [12:0] v_addr,
    output logic [7:0]  v_din,
    input  logic [7:0]  v_dout,
    input  logic        v_rdy
);

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RDW  = 3'd2;
    localparam logic [2:0] S_RDS  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_WRW  = 3'd5;
    localparam logic [2:0] S_WRS  = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    logic          mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          ie_q, ie_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          irq_q, irq_d;
    logic          bus_req_q, bus_req_d;
    logic          v_sel_q, v_sel_d;
    logic          v_we_q, v_we_d;
    logic [AW-1:0] v_addr_q, v_addr_d;
    logic [DW-1:0] v_din_q, v_din_d;

    logic          busy_c;
    logic          ctrl_wr_c;
    logic          abort_now_c;
    logic          adv_c;
    logic [AW-1:0] step_c;

    assign busy_c      = (state_q != S_IDLE);
    assign ctrl_wr_c   = sel && we && (addr == 3'd7);
    assign abort_now_c = abort_q || (ctrl_wr_c && busy_c && din[4]);
    assign step_c      = dir_q ? {AW{1'b1}} : AW'(1);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            dir_q     <= 1'b0;
            ie_q      <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            dout_q    <= '0;
            irq_q     <= 1'b0;
            bus_req_q <= 1'b0;
            v_sel_q   <= 1'b0;
            v_we_q    <= 1'b0;
            v_addr_q  <= '0;
            v_din_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            ie_q      <= ie_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
            bus_req_q <= bus_req_d;
            v_sel_q   <= v_sel_d;
            v_we_q    <= v_we_d;
            v_addr_q  <= v_addr_d;
            v_din_q   <= v_din_d;
        end
    end

    // Register file, transfer FSM and next output values
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        fill_d    = fill_q;
        data_d    = data_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        ie_d      = ie_q;
        done_d    = done_q;
        abort_d   = abort_q;
        dout_d    = dout_q;
        v_addr_d  = v_addr_q;
        v_din_d   = v_din_q;
        adv_c     = 1'b0;

        if (sel && we && !busy_c) begin
            case (addr)
                3'd0:    src_d[7:0]  = din;
                3'd1:    src_d[12:8] = din[4:0];
                3'd2:    dst_d[7:0]  = din;
                3'd3:    dst_d[12:8] = din[4:0];
                3'd4:    len_d[7:0]  = din;
                3'd5:    len_d[12:8] = din[4:0];
                3'd6:    fill_d      = din;
                default: begin
                    mode_d = din[1];
                    dir_d  = din[2];
                    ie_d   = din[3];
                end
            endcase
        end
        if (ctrl_wr_c && din[6]) done_d = 1'b0;
        if (ctrl_wr_c && busy_c && din[4]) abort_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                // start overrides a simultaneous done-clear
                if (ctrl_wr_c && din[0]) begin
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        done_d  = 1'b0;
                        state_d = din[1] ? S_RD : S_WR;
                    end
                end
            end
            S_RD:  state_d = S_RDW;
            S_RDW: begin
                if (v_rdy) begin
                    data_d  = v_dout;
                    state_d = abort_now_c ? S_IDLE : S_WR;
                end else begin
                    state_d = S_RDS;
                end
            end
            S_RDS: begin
                data_d  = v_dout;
                state_d = abort_now_c ? S_IDLE : S_WR;
            end
            S_WR:  state_d = S_WRW;
            S_WRW: begin
                if (v_rdy) adv_c = 1'b1;
                else       state_d = S_WRS;
            end
            S_WRS: adv_c = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Byte retired: step pointers and pick the next iteration
        if (adv_c) begin
            len_d = len_q - AW'(1);
            dst_d = dst_q + step_c;
            if (mode_q) src_d = src_q + step_c;
            if (abort_now_c) begin
                state_d = S_IDLE;
            end else if (len_d == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = mode_q ? S_RD : S_WR;
            end
        end

        if (state_d == S_IDLE) abort_d = 1'b0;

        bus_req_d = (state_d != S_IDLE);
        v_sel_d   = (state_d == S_RD) || (state_d == S_WR);
        v_we_d    = (state_d == S_WR);
        if (state_d == S_RD) v_addr_d = src_d;
        if (state_d == S_WR) begin
            v_addr_d = dst_d;
            v_din_d  = mode_d ? data_d : fill_q;
        end
        irq_d = done_d && ie_d;

        if (sel && !we) begin
            case (addr)
                3'd0:    dout_d = src_q[7:0];
                3'd1:    dout_d = {3'b000, src_q[12:8]};
                3'd2:    dout_d = dst_q[7:0];
                3'd3:    dout_d = {3'b000, dst_q[12:8]};
                3'd4:    dout_d = len_q[7:0];
                3'd5:    dout_d = {3'b000, len_q[12:8]};
                3'd6:    dout_d = fill_q;
                default: dout_d = {busy_c, done_q, 2'b00, ie_q, dir_q, mode_q, 1'b0};
            endcase
        end
    end

    assign dout    = dout_q;
    assign irq     = irq_q;
    assign bus_req = bus_req_q;
    assign v_sel   = v_sel_q;
    assign v_we    = v_we_q;
    assign v_addr  = v_addr_q;
    assign v_din   = v_din_q;

endmodule

// File: doc/vram_dma.md
VRAM_DMA -- requirements
Module: vram_dma

Interface
REQ-001 SHALL have port clk, input, 1 bit: 16MHz system clock, same clock as the video block.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port sel, input, 1 bit: CPU register-window select.
REQ-004 SHALL have port we, input, 1 bit: CPU write enable.
REQ-005 SHALL have port addr, input, 3 bits: register index.
REQ-006 SHALL have port din, input, 8 bits: CPU write data.
REQ-007 SHALL have port dout, output, 8 bits: CPU read data, registered.
REQ-008 SHALL have port irq, output, 1 bit: completion interrupt, active high.
REQ-009 SHALL have port bus_req, output, 1 bit: high while an operation is in progress; the top level routes the video CPU port to this block while bus_req is high.
REQ-010 SHALL have ports v_sel and v_we, outputs, 1 bit each: video-port select and write enable.
REQ-011 SHALL have port v_addr, output, 13 bits: VRAM byte address within the bank.
REQ-012 SHALL have port v_din, output, 8 bits: VRAM write data.
REQ-013 SHALL have port v_dout, input, 8 bits: VRAM read data.
REQ-014 SHALL have port v_rdy, input, 1 bit: active-low stall from the video block.

Function
REQ-015 Register map SHALL be: 0 SRC_L; 1 SRC_H[4:0]; 2 DST_L; 3 DST_H[4:0]; 4 LEN_L; 5 LEN_H[4:0]; 6 FILL; 7 CTRL/STAT.
REQ-016 CTRL write bits SHALL be: b0 start; b1 mode (0=fill, 1=copy); b2 dir (0=ascending, 1=descending); b3 irq enable; b4 abort; b6 write-1-to-clear done.
REQ-017 STAT read SHALL return {busy, done, 1'b0, 1'b0, ie, dir, mode, 1'b0}.
REQ-018 Register reads SHALL place data on dout on the cycle after sel is high with we low.
REQ-019 While busy, writes to registers 0-6 SHALL be ignored, and CTRL writes SHALL act only on b4 and b6.
REQ-020 FSM states SHALL be IDLE, RD, RDW, RDS, WR, WRW, WRS.
- start in IDLE with LEN≠0: copy goes to RD, fill goes to WR.
- start with LEN=0: done=1, no bus access.
REQ-021 RD SHALL drive v_sel=1, v_we=0 and v_addr=SRC for one cycle, then go to RDW.
REQ-022 RDW SHALL behave as follows:
- v_rdy=1: capture v_dout, go to WR.
- v_rdy=0: go to RDS, capture v_dout in RDS, then go to WR.
REQ-023 WR SHALL drive v_sel=1, v_we=1, v_addr=DST and v_din (FILL or the captured byte) for one cycle, then go to WRW.
REQ-024 WRW SHALL behave as follows:
- v_rdy=0: go to WRS for one idle cycle.
- Then: decrement LEN; step SRC (copy only) and DST by +1, or by -1 if dir=1.
- If LEN becomes 0: go to IDLE and set done; otherwise go to RD (copy) or WR (fill).
REQ-025 v_sel SHALL be 0 in every state other than RD and WR; no access SHALL be issued in a cycle where v_rdy=0.
REQ-026 Throughput SHALL be: fill 2 clocks/byte, copy 4 clocks/byte, plus 1 clock per stall.
REQ-027 Address arithmetic SHALL be modulo 8192; 0x1FFF+1 wraps to 0x0000 and 0x0000-1 wraps to 0x1FFF.
REQ-028 LEN SHALL be 13 bits, with a maximum of 8191 bytes.
REQ-029 Abort SHALL let any outstanding access finish through its W/S state, then go to IDLE without setting done; SRC, DST and LEN SHALL hold their advanced values.
REQ-030 busy and bus_req SHALL be high from the cycle after the start write until the cycle IDLE is re-entered.
REQ-031 irq SHALL equal done AND ie; done SHALL be cleared by a CTRL b6 write or by a new start.
REQ-032 If a start write and a done-clear write occur in the same cycle, start SHALL take priority and done SHALL read 0.

Reset
REQ-033 On reset_n=0, asynchronously: state=IDLE; all registers=0; dout=0; irq=0; bus_req=0; v_sel=0; v_we=0; v_addr=0; v_din=0.
REQ-034 Reset asserted mid-operation SHALL abandon the transfer immediately, and a partially written VRAM SHALL be acceptable.

Verification
REQ-035 Fill: DST=0x0000, LEN=32, FILL=0x20, start with mode=0 and no stalls -> 32 writes to addresses 0-31, done after 64 clocks, irq high if ie=1.
REQ-036 Copy scroll: SRC=0x0020, DST=0x0000, LEN=0x3E0, ascending -> VRAM[n]=old VRAM[n+32] for n<0x3E0, and 3968 clocks total with no stalls.
REQ-037 Stall: hold v_rdy=0 on the cycle after each RD -> each read data byte is captured in RDS and is correct, and no v_sel is asserted while v_rdy=0.
REQ-038 Wrap: DST=0x1FFE, LEN=4, fill 0xAA -> writes land at 0x1FFE, 0x1FFF, 0x0000, 0x0001; repeat with dir=1 at DST=0x0001 -> 0x0001, 0x0000, 0x1FFF, 0x1FFE.
REQ-039 Abort after 3 bytes of LEN=10 -> exactly 3 writes, done=0, LEN reads back 7.
REQ-040 Pulse reset_n low mid-copy -> all outputs read 0 on the same cycle, STAT=0x00.
